// File: rtl/auto_pipe_credit_pkg.sv
// Shared types and helpers for the auto-pipeline credit controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package auto_pipe_credit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_WAIT_ECHO,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // The probe marker lives at bit DATA_WIDTH + PROBE_BIT_OFFSET of the chain word.
  localparam int PROBE_BIT_OFFSET = 0;

  // Width needed to hold a credit count of 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/auto_pipe_credit_ctrl_if.sv
// Bundles producer handshake, forward-chain drive and far-end return signals.
// Latency: n/a (wiring only).
// Backpressure: in_ready is driven by the controller (slave modport).
// Ports: in_valid/in_data/in_ready producer side; chain_enable_out/chain_data_out to
//        the forward chain; credit_return_in/probe_echo_in from the return chain.
interface auto_pipe_credit_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  chain_enable_out;
  logic [DATA_WIDTH:0]   chain_data_out;
  logic                  credit_return_in;
  logic                  probe_echo_in;

  // Controller side.
  modport slave (
    input  in_valid, in_data, credit_return_in, probe_echo_in,
    output in_ready, chain_enable_out, chain_data_out
  );

  // Producer / chain environment side.
  modport master (
    output in_valid, in_data, credit_return_in, probe_echo_in,
    input  in_ready, chain_enable_out, chain_data_out
  );
endinterface

// File: rtl/auto_pipe_credit_counter.sv
// Saturating credit counter: +1 per returned credit, -1 per transfer, net zero when both.
// Latency: count updates on the clock edge after inc/dec.
// Backpressure: zero flags exhaustion; a return while full saturates and sets sticky overflow.
// Ports: clk, rst_n, inc, dec in; count, zero, full, overflow out.
module auto_pipe_credit_counter
  import auto_pipe_credit_pkg::*;
#(
  parameter  int CREDITS = 16,
  localparam int CRED_W  = credit_width(CREDITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] count,
  output logic              zero,
  output logic              full,
  output logic              overflow
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  logic [CRED_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (inc && !dec) begin
      if (count_q == CRED_MAX) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CRED_W'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CRED_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= CRED_MAX;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign zero     = (count_q == '0);
  assign full     = (count_q == CRED_MAX);
  assign overflow = overflow_q;

endmodule

// File: rtl/auto_pipe_credit_ctrl.sv
// Credit flow controller feeding an auto-pipelined register chain; measures chain round trip with a probe token.
// Latency: input handshake -> chain_enable_out 1 cycle; credit_return_in -> in_ready 1 cycle.
// Backpressure: in_ready only in RUN with credits left, so the far-end FIFO is never overrun.
// Ports: clk, rst_n, calibrate_in plain; bus (slave) carries producer handshake, chain drive,
//        credit return and probe echo; rtt_out, rtt_valid_out, timeout_out, overflow_err_out, credits_out status.
module auto_pipe_credit_ctrl
  import auto_pipe_credit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int CREDITS    = 16,
  parameter  int MAX_RTT    = 255,
  parameter  int CNT_W      = $clog2(MAX_RTT + 1),
  localparam int CRED_W     = credit_width(CREDITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                calibrate_in,
  auto_pipe_credit_ctrl_if.slave bus,
  output logic [CNT_W-1:0]    rtt_out,
  output logic                rtt_valid_out,
  output logic                timeout_out,
  output logic                overflow_err_out,
  output logic [CRED_W-1:0]   credits_out
);

  localparam int                  CW1        = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] PROBE_WORD = CW1'(1) << (DATA_WIDTH + PROBE_BIT_OFFSET);
  // Last counter value at which an echo still counts; the next cycle would make the RTT exceed MAX_RTT.
  localparam logic [CNT_W-1:0]    RTT_LAST   = CNT_W'(MAX_RTT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rtt_cnt_q, rtt_cnt_d;
  logic [CNT_W-1:0]    rtt_q, rtt_d;
  logic                rtt_vld_q, rtt_vld_d;
  logic                timeout_q, timeout_d;
  logic                chain_en_q, chain_en_d;
  logic [DATA_WIDTH:0] chain_dat_q, chain_dat_d;

  logic                in_ready;
  logic                xfer;
  logic                cred_zero;
  logic                cred_full;
  logic                cred_ovf;
  logic [CRED_W-1:0]   cred_count;

  // Combinational from registered state and count so credit returns reach in_ready in one cycle.
  assign in_ready = (state_q == ST_RUN) && !cred_zero;
  assign xfer     = bus.in_valid && in_ready;

  auto_pipe_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credits (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (bus.credit_return_in),
    .dec      (xfer),
    .count    (cred_count),
    .zero     (cred_zero),
    .full     (cred_full),
    .overflow (cred_ovf)
  );

  always_comb begin
    state_d     = state_q;
    rtt_cnt_d   = rtt_cnt_q;
    rtt_d       = rtt_q;
    rtt_vld_d   = rtt_vld_q;
    timeout_d   = timeout_q;
    chain_en_d  = 1'b0;
    chain_dat_d = chain_dat_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_PROBE;
      end

      // The probe is launched without touching the credit count.
      ST_PROBE: begin
        chain_en_d  = 1'b1;
        chain_dat_d = PROBE_WORD;
        rtt_cnt_d   = '0;
        state_d     = ST_WAIT_ECHO;
      end

      // Counter is 0 in the cycle the probe is on chain_enable_out, hence the +1.
      ST_WAIT_ECHO: begin
        if (bus.probe_echo_in) begin
          rtt_d     = rtt_cnt_q + CNT_W'(1);
          rtt_vld_d = 1'b1;
          timeout_d = 1'b0;
          state_d   = ST_RUN;
        end else if (rtt_cnt_q == RTT_LAST) begin
          rtt_vld_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          rtt_cnt_d = rtt_cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (xfer) begin
          chain_en_d  = 1'b1;
          chain_dat_d = {1'b0, bus.in_data};
        end
        if (calibrate_in) begin
          state_d = ST_DRAIN;
        end
      end

      // Waiting for every credit back guarantees the chain is empty of payload while probing.
      ST_DRAIN: begin
        if (cred_full) begin
          state_d = ST_PROBE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rtt_cnt_q   <= '0;
      rtt_q       <= '0;
      rtt_vld_q   <= 1'b0;
      timeout_q   <= 1'b0;
      chain_en_q  <= 1'b0;
      chain_dat_q <= '0;
    end else begin
      state_q     <= state_d;
      rtt_cnt_q   <= rtt_cnt_d;
      rtt_q       <= rtt_d;
      rtt_vld_q   <= rtt_vld_d;
      timeout_q   <= timeout_d;
      chain_en_q  <= chain_en_d;
      chain_dat_q <= chain_dat_d;
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.chain_enable_out = chain_en_q;
  assign bus.chain_data_out   = chain_dat_q;
  assign rtt_out              = rtt_q;
  assign rtt_valid_out        = rtt_vld_q;
  assign timeout_out          = timeout_q;
  assign overflow_err_out     = cred_ovf;
  assign credits_out          = cred_count;

endmodule

// File: tb/tb_auto_pipe_credit_ctrl.sv
// Self-checking bench: table of RUN-state credit vectors, hand-timed calibration sequences,
// then random traffic against a far-end FIFO / return-chain model.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_auto_pipe_credit_ctrl;

  localparam int DW        = 16;
  localparam int CRED      = 4;
  localparam int MRTT      = 20;
  localparam int CNT_W     = $clog2(MRTT + 1);
  localparam int CRW       = $clog2(CRED + 1);
  localparam int FWD_DEPTH = 3;
  localparam int RET_DEPTH = 2;
  localparam logic [31:0] PROBE_W = 32'h0001_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             calibrate_in = 1'b0;
  logic [CNT_W-1:0] rtt_out;
  logic             rtt_valid_out;
  logic             timeout_out;
  logic             overflow_err_out;
  logic [CRW-1:0]   credits_out;

  auto_pipe_credit_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  auto_pipe_credit_ctrl #(
    .DATA_WIDTH (DW),
    .CREDITS    (CRED),
    .MAX_RTT    (MRTT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .calibrate_in     (calibrate_in),
    .bus              (bus),
    .rtt_out          (rtt_out),
    .rtt_valid_out    (rtt_valid_out),
    .timeout_out      (timeout_out),
    .overflow_err_out (overflow_err_out),
    .credits_out      (credits_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int probe_cyc = -1000;
  bit echo_on = 1'b0;
  int echo_gap = 6;

  typedef struct {
    logic        v;
    logic        r;
    logic [15:0] d;
    logic        e_rdy;
    logic [2:0]  e_cred;
    logic        e_en;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Advance to the next cycle and drive defaults; the far-end loop echoes a probe echo_gap cycles after it was seen.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.in_valid         = 1'b0;
    bus.credit_return_in = 1'b0;
    calibrate_in         = 1'b0;
    bus.probe_echo_in    = echo_on && (cyc == probe_cyc + echo_gap);
  endtask

  task automatic sample();
    @(negedge clk);
    if (bus.chain_enable_out && bus.chain_data_out[DW]) probe_cyc = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      next_cycle();
      sample();
    end
  endtask

  // Calibration from RUN with all credits home: DRAIN exits at once, probe visible 3 cycles after the request.
  task automatic calib_full(input string tag);
    int c;
    next_cycle();
    calibrate_in = 1'b1;
    c = cyc;
    sample();
    step(3);
    check({tag, "_probe_cycle"}, 32'(probe_cyc), 32'(c + 3));
    check({tag, "_probe_word"}, 32'(bus.chain_data_out), PROBE_W);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          p;
    int          m_credits;
    int          occ;
    int          arr_q [$];
    int          ret_q [$];
    bit          exp_en_next;
    logic [DW:0] exp_dat_next;
    bit          xfer;

    // RUN-state vectors with CREDITS=4: drain to zero, single-credit refill, simultaneous
    // transfer+return, refill to full, then an extra return that must saturate and flag overflow.
    vecs[0]  = '{1'b1, 1'b0, 16'hA000, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'hA001, 1'b1, 3'd3, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'hA002, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'hA003, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'hA004, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'hA005, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'hA006, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'hA007, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'hA008, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'hA009, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'hA00A, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'hA00B, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'hA00C, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'hA00D, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 16'hA00E, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 16'hA00F, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 16'hA010, 1'b1, 3'd4, 1'b0, 1'b1};

    bus.in_valid         = 1'b0;
    bus.in_data          = '0;
    bus.credit_return_in = 1'b0;
    bus.probe_echo_in    = 1'b0;

    // ---- reset and automatic calibration, echo lands in the 7th cycle counting the probe cycle ----
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 0;
    probe_cyc = -1000;
    echo_on   = 1'b1;
    echo_gap  = 6;
    sample();
    check("rst_chain_en", 32'(bus.chain_enable_out), 32'd0);
    check("rst_chain_dat", 32'(bus.chain_data_out), 32'd0);
    check("rst_rtt", 32'(rtt_out), 32'd0);
    check("rst_rtt_valid", 32'(rtt_valid_out), 32'd0);
    check("rst_timeout", 32'(timeout_out), 32'd0);
    check("rst_overflow", 32'(overflow_err_out), 32'd0);
    check("rst_credits", 32'(credits_out), 32'(CRED));
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step(1);
    check("probe_cycle1_en", 32'(bus.chain_enable_out), 32'd0);
    step(1);
    check("probe_cycle2_en", 32'(bus.chain_enable_out), 32'd1);
    check("probe_cycle2_dat", 32'(bus.chain_data_out), PROBE_W);
    step(6);
    check("wait_echo_rdy", 32'(bus.in_ready), 32'd0);
    step(1);
    check("rtt_first", 32'(rtt_out), 32'd7);
    check("rtt_valid_first", 32'(rtt_valid_out), 32'd1);
    check("run_in_ready", 32'(bus.in_ready), 32'd1);

    // ---- table-driven RUN vectors ----
    for (int i = 0; i < 17; i++) begin
      next_cycle();
      bus.in_valid         = vecs[i].v;
      bus.in_data          = vecs[i].d;
      bus.credit_return_in = vecs[i].r;
      sample();
      check($sformatf("vec%0d_rdy", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_cred", i), 32'(credits_out), 32'(vecs[i].e_cred));
      check($sformatf("vec%0d_en", i), 32'(bus.chain_enable_out), 32'(vecs[i].e_en));
      check($sformatf("vec%0d_ovf", i), 32'(overflow_err_out), 32'(vecs[i].e_ovf));
      if (vecs[i].e_en && i > 0)
        check($sformatf("vec%0d_dat", i), 32'(bus.chain_data_out), 32'(vecs[i-1].d));
    end

    // ---- calibrate with 3 credits outstanding ----
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hC000 + 16'(i);
      sample();
    end
    next_cycle();
    calibrate_in = 1'b1;
    sample();
    check("cal_credits", 32'(credits_out), 32'd1);
    check("cal_rdy_same_cycle", 32'(bus.in_ready), 32'd1);
    echo_gap = 9;
    for (int r = 0; r < 3; r++) begin
      next_cycle();
      bus.in_valid         = 1'b1;
      bus.credit_return_in = 1'b1;
      sample();
      check($sformatf("drain%0d_rdy_a", r), 32'(bus.in_ready), 32'd0);
      check($sformatf("drain%0d_en_a", r), 32'(bus.chain_enable_out), 32'd0);
      next_cycle();
      bus.in_valid = 1'b1;
      sample();
      check($sformatf("drain%0d_rdy_b", r), 32'(bus.in_ready), 32'd0);
      check($sformatf("drain%0d_en_b", r), 32'(bus.chain_enable_out), 32'd0);
    end
    step(1);
    check("drain_probe_not_yet", 32'(bus.chain_enable_out), 32'd0);
    check("drain_credits_full", 32'(credits_out), 32'(CRED));
    step(1);
    check("drain_probe_cycle", 32'(probe_cyc), 32'(cyc));
    check("drain_probe_word", 32'(bus.chain_data_out), PROBE_W);
    step(10);
    check("rtt_second", 32'(rtt_out), 32'd10);
    check("rtt_valid_second", 32'(rtt_valid_out), 32'd1);

    // ---- probe timeout with MAX_RTT = 20 ----
    echo_on = 1'b0;
    calib_full("tmo");
    p = probe_cyc;
    step(19);
    check("tmo_not_yet", 32'(timeout_out), 32'd0);
    check("tmo_wait_rdy", 32'(bus.in_ready), 32'd0);
    step(1);
    check("tmo_cycle", 32'(cyc - p), 32'd20);
    check("tmo_flag", 32'(timeout_out), 32'd1);
    check("tmo_rtt_valid", 32'(rtt_valid_out), 32'd0);
    check("tmo_rtt_kept", 32'(rtt_out), 32'd10);
    check("tmo_run_rdy", 32'(bus.in_ready), 32'd1);
    next_cycle();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    sample();
    step(1);
    check("tmo_traffic_en", 32'(bus.chain_enable_out), 32'd1);
    check("tmo_traffic_dat", 32'(bus.chain_data_out), 32'h0000_1234);
    // A stray echo in RUN must not change the measurement.
    next_cycle();
    bus.probe_echo_in = 1'b1;
    sample();
    step(1);
    check("stray_echo_valid", 32'(rtt_valid_out), 32'd0);
    check("stray_echo_tmo", 32'(timeout_out), 32'd1);
    next_cycle();
    bus.credit_return_in = 1'b1;
    sample();
    step(1);
    check("refill_credits", 32'(credits_out), 32'(CRED));

    // ---- successful re-probe clears the timeout ----
    echo_on  = 1'b1;
    echo_gap = 3;
    calib_full("recal");
    step(4);
    check("recal_rtt", 32'(rtt_out), 32'd4);
    check("recal_valid", 32'(rtt_valid_out), 32'd1);
    check("recal_tmo_clear", 32'(timeout_out), 32'd0);

    // ---- random traffic against far-end FIFO and return-chain model ----
    m_credits    = CRED;
    occ          = 0;
    exp_en_next  = 1'b0;
    exp_dat_next = '0;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = DW'($urandom);
      if (ret_q.size() > 0 && ret_q[0] == cyc) begin
        bus.credit_return_in = 1'b1;
        void'(ret_q.pop_front());
      end
      sample();
      check("rnd_en", 32'(bus.chain_enable_out), 32'(exp_en_next));
      if (exp_en_next) check("rnd_dat", 32'(bus.chain_data_out), 32'(exp_dat_next));
      check("rnd_credits", 32'(credits_out), 32'(m_credits));
      check("rnd_rdy", 32'(bus.in_ready), 32'(m_credits != 0));
      xfer         = bus.in_valid && (m_credits != 0);
      exp_en_next  = xfer;
      exp_dat_next = {1'b0, bus.in_data};
      m_credits    = m_credits - int'(xfer) + int'(bus.credit_return_in);
      if (bus.chain_enable_out) arr_q.push_back(cyc + FWD_DEPTH);
      while (arr_q.size() > 0 && arr_q[0] == cyc) begin
        occ++;
        void'(arr_q.pop_front());
      end
      check("rnd_fifo_overrun", 32'(occ > CRED), 32'd0);
      if (occ > 0 && $urandom_range(0, 2) == 0) begin
        occ--;
        ret_q.push_back(cyc + RET_DEPTH);
      end
    end
    check("ovf_sticky", 32'(overflow_err_out), 32'd1);

    // ---- mid-operation reset drops everything, then re-calibrates ----
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_credits", 32'(credits_out), 32'(CRED));
    check("midrst_ovf", 32'(overflow_err_out), 32'd0);
    check("midrst_en", 32'(bus.chain_enable_out), 32'd0);
    check("midrst_dat", 32'(bus.chain_data_out), 32'd0);
    check("midrst_rtt_valid", 32'(rtt_valid_out), 32'd0);
    check("midrst_rtt", 32'(rtt_out), 32'd0);
    check("midrst_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    cyc          = 0;
    probe_cyc    = -1000;
    sample();
    step(2);
    check("midrst_reprobe", 32'(probe_cyc), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/auto_pipe_credit_ctrl.md
Name: auto_pipe_credit_ctrl

Overview:
- Credit-based flow controller that drives the input of a variable-depth auto-pipeline register chain from a ready/valid producer.
- The far end of the chain feeds a receive FIFO of depth CREDITS. Each FIFO pop returns a one-cycle credit pulse, and that pulse travels back through a return chain.
- The controller never overruns the FIFO, whatever chain depth the EDA tool chooses.
- After reset, and on request, it sends a probe token and measures the actual round-trip latency. The result goes to status/debug logic.

Parameters:
- DATA_WIDTH, 32, payload width. The chain carries DATA_WIDTH+1 bits, with the MSB used as the probe marker.
- CREDITS, 16, far-end FIFO depth and the initial credit count (1..255).
- MAX_RTT, 255, probe timeout in cycles (1..65535).
- CNT_W, $clog2(MAX_RTT+1), derived width of the RTT counter. Do not override.

Ports:
- clk, in, 1: sole clock.
- rst_n, in, 1: reset, asynchronous and active-low.
- calibrate_in, in, 1: one-cycle request to re-measure RTT.
- in_valid, in, 1: producer data valid.
- in_data, in, DATA_WIDTH: producer payload.
- in_ready, out, 1: controller accepts in_data this cycle.
- chain_enable_out, out, 1: drives the enable_in of the forward chain.
- chain_data_out, out, DATA_WIDTH+1: drives the data_in of the forward chain. Bit DATA_WIDTH is the probe marker.
- credit_return_in, in, 1: one credit returned this cycle.
- probe_echo_in, in, 1: the far end has looped the probe back.
- rtt_out, out, CNT_W: last measured round-trip latency in cycles.
- rtt_valid_out, out, 1: rtt_out holds a successful measurement.
- timeout_out, out, 1: sticky. The last probe timed out.
- overflow_err_out, out, 1: sticky. A credit was returned while the count was already CREDITS.
- credits_out, out, $clog2(CREDITS+1): current credit count.

Behaviour:
- Reset values:
  - state IDLE; credits = CREDITS.
  - chain_enable_out, chain_data_out, rtt_out, rtt_valid_out, timeout_out and overflow_err_out are all 0.
- States: IDLE, PROBE, WAIT_ECHO, RUN, DRAIN.
- IDLE:
  - in_ready = 0.
  - Moves unconditionally to PROBE on the next cycle, so calibration is automatic after reset.
- PROBE (1 cycle):
  - Registers chain_enable_out = 1 and chain_data_out = {1'b1, '0}.
  - Clears the RTT counter, then moves to WAIT_ECHO.
  - The probe consumes no credit.
- WAIT_ECHO:
  - The counter increments every cycle.
  - On probe_echo_in, rtt_out = counter + 1, which is the cycle count from the probe appearing on chain_enable_out to the echo. Then rtt_valid_out = 1, timeout_out = 0, and the state moves to RUN.
  - If the counter reaches MAX_RTT with no echo: timeout_out = 1, rtt_valid_out = 0, and the state moves to RUN.
- RUN:
  - in_ready = (credits != 0). This is combinational from registered state and count.
  - A transfer is in_valid & in_ready.
  - On the cycle after a transfer: chain_enable_out = 1 and chain_data_out = {1'b0, in_data}.
  - Otherwise chain_enable_out = 0 and chain_data_out holds its value.
- DRAIN:
  - calibrate_in in RUN forces in_ready = 0 from the next cycle.
  - The controller waits until credits == CREDITS, then moves to PROBE. This means no payload is in flight during a probe.
  - calibrate_in in any other state is ignored.
- Credit arithmetic (applies in every state):
  - transfer only: -1. credit_return only: +1. Both in the same cycle: unchanged.
  - A return that would exceed CREDITS saturates at CREDITS and sets overflow_err_out.
  - The count can never go below 0, because in_ready gates transfers.
- probe_echo_in outside WAIT_ECHO is ignored.
- Latency:
  - Input handshake to chain_enable_out is 1 cycle.
  - credit_return_in to the updated in_ready is 1 cycle.
- Sticky flags clear only on rst_n, except timeout_out, which is cleared by a successful probe.
- Asserting rst_n mid-operation drops everything immediately. After release, the block re-calibrates.
- The integrator is responsible for sizing the FIFO so that CREDITS ≥ the maximum RTT. This block does not check it.

Decomposition:
- Package auto_pipe_credit_pkg holds:
  - the state_t enum;
  - the constant PROBE_BIT_OFFSET = 0, giving the marker at bit DATA_WIDTH+PROBE_BIT_OFFSET;
  - a function credit_width(CREDITS).
- Sub-module auto_pipe_credit_counter holds the saturating up/down counter:
  - inputs: inc, dec;
  - outputs: count, zero, full, overflow.
- The FSM, RTT counter and output registers stay in the top module.

Test Plan:
- Reset, with an external loop echoing the probe 7 cycles later:
  - chain_enable_out shows a probe (MSB = 1) in cycle 2;
  - rtt_out = 7 and rtt_valid_out = 1;
  - in_ready rises in RUN.
- CREDITS = 4, in_valid held high, no returns:
  - exactly 4 transfers, then in_ready = 0 and credits_out = 0;
  - a single credit_return_in gives exactly one more transfer.
- With credits = 2, a transfer and a credit_return_in in the same cycle: credits_out stays 2 and the payload appears on chain_data_out the next cycle.
- No echo, MAX_RTT = 20:
  - timeout_out = 1 twenty cycles after the probe;
  - rtt_valid_out = 0;
  - RUN is entered and traffic flows.
- calibrate_in with 3 credits outstanding:
  - in_ready = 0;
  - PROBE is issued only after the 3rd return (credits = CREDITS);
  - a new rtt_out is reported.
- Extra credit_return_in with credits = CREDITS: count stays at CREDITS and overflow_err_out = 1 until reset.
